// File: rtl/dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_port_arbiter
// Purpose  : Shares one data-memory port between execute loads and committed
//            stores, with store starvation protection and flush-aware load FSM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package Purple_Jade_pkg;
  localparam int WORD_SIZE = 32;
endpackage

module dmem_port_arbiter
  import Purple_Jade_pkg::*;
#(
  parameter int WORD_SIZE_P  = WORD_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   ld_req_v_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   ld_ready_o,
  output logic                   ld_resp_v_o,
  output logic [WORD_SIZE_P-1:0] ld_resp_data_o,
  input  logic                   sb_mem_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
  output logic                   sb_mem_yumi_o,
  input  logic                   rob_mispredict_i,
  output logic                   mem_v_o,
  output logic                   mem_w_o,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_data_o,
  input  logic                   mem_ready_i,
  input  logic                   mem_rdata_v_i,
  input  logic [WORD_SIZE_P-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_WAIT = 2'd1;
  localparam logic [1:0] SQUASH  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic w_ld_elig;
  logic w_st_elig;
  logic w_st_win;
  logic w_ld_win;

  // Reset gates eligibility so every output is quiet while reset is held.
  assign w_ld_elig = ld_req_v_i & (state_q == IDLE) & ~rob_mispredict_i & ~reset_i;
  assign w_st_elig = sb_mem_v_i & ~reset_i;
  assign w_st_win  = w_st_elig & (~w_ld_elig | (starve_cnt_q == STARVE_MAX));
  assign w_ld_win  = w_ld_elig & ~w_st_win;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_ld_win && mem_ready_i) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_rdata_v_i)         state_d = IDLE;
        else if (rob_mispredict_i) state_d = SQUASH;
      end
      SQUASH: begin
        if (mem_rdata_v_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only cycles where a store actually loses to a load count as starvation;
    // plain memory backpressure leaves the counter untouched.
    starve_cnt_d = starve_cnt_q;
    if (!sb_mem_v_i || (w_st_win && mem_ready_i)) begin
      starve_cnt_d = '0;
    end else if (w_st_elig && w_ld_win && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    mem_v_o        = w_ld_elig | w_st_elig;
    mem_w_o        = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    ld_ready_o     = w_ld_win & mem_ready_i;
    sb_mem_yumi_o  = w_st_win & mem_ready_i;
    ld_resp_v_o    = 1'b0;
    ld_resp_data_o = '0;

    if (w_st_win) begin
      mem_w_o    = 1'b1;
      mem_addr_o = sb_mem_addr_i;
      mem_data_o = sb_mem_data_i;
    end else if (w_ld_win) begin
      mem_addr_o = ld_addr_i;
    end

    if ((state_q == LD_WAIT) && mem_rdata_v_i && !rob_mispredict_i && !reset_i) begin
      ld_resp_v_o    = 1'b1;
      ld_resp_data_o = mem_rdata_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_port_arbiter
// Purpose  : Directed scoreboard bench for dmem_port_arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         ld_req_v_i;
  logic [W-1:0] ld_addr_i;
  logic         ld_ready_o;
  logic         ld_resp_v_o;
  logic [W-1:0] ld_resp_data_o;
  logic         sb_mem_v_i;
  logic [W-1:0] sb_mem_addr_i;
  logic [W-1:0] sb_mem_data_i;
  logic         sb_mem_yumi_o;
  logic         rob_mispredict_i;
  logic         mem_v_o;
  logic         mem_w_o;
  logic [W-1:0] mem_addr_o;
  logic [W-1:0] mem_data_o;
  logic         mem_ready_i;
  logic         mem_rdata_v_i;
  logic [W-1:0] mem_rdata_i;

  dmem_port_arbiter #(.WORD_SIZE_P(W), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ld_req_v_i(ld_req_v_i), .ld_addr_i(ld_addr_i), .ld_ready_o(ld_ready_o),
    .ld_resp_v_o(ld_resp_v_o), .ld_resp_data_o(ld_resp_data_o),
    .sb_mem_v_i(sb_mem_v_i), .sb_mem_addr_i(sb_mem_addr_i),
    .sb_mem_data_i(sb_mem_data_i), .sb_mem_yumi_o(sb_mem_yumi_o),
    .rob_mispredict_i(rob_mispredict_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_v_i(mem_rdata_v_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         w;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic         ldr;
    logic         yumi;
  } mem_exp_t;

  mem_exp_t     mem_q[$];
  logic [W-1:0] resp_q[$];
  mem_exp_t     me;
  logic [W-1:0] re;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setin(input logic ldv, input logic [W-1:0] lda, input logic sbv,
                       input logic [W-1:0] sba, input logic [W-1:0] sbd, input logic mis,
                       input logic rdy, input logic rdv, input logic [W-1:0] rdata);
    ld_req_v_i       = ldv;
    ld_addr_i        = lda;
    sb_mem_v_i       = sbv;
    sb_mem_addr_i    = sba;
    sb_mem_data_i    = sbd;
    rob_mispredict_i = mis;
    mem_ready_i      = rdy;
    mem_rdata_v_i    = rdv;
    mem_rdata_i      = rdata;
  endtask

  task automatic exp_mem(input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic ldr, input logic yumi);
    mem_exp_t e;
    e.w = w; e.addr = a; e.data = d; e.ldr = ldr; e.yumi = yumi;
    mem_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: each mid-cycle sample consumes exactly the expectations pushed for that cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("mem_v_o", mem_v_o, mem_q.size() != 0);
      if (mem_q.size() != 0) begin
        me = mem_q.pop_front();
        chk("mem_w_o", mem_w_o, me.w);
        chk("mem_addr_o", mem_addr_o, me.addr);
        chk("mem_data_o", mem_data_o, me.data);
        chk("ld_ready_o", ld_ready_o, me.ldr);
        chk("sb_mem_yumi_o", sb_mem_yumi_o, me.yumi);
      end else begin
        chk("idle_ctrl", {mem_w_o, ld_ready_o, sb_mem_yumi_o}, 3'b000);
        chk("idle_addr", mem_addr_o, 0);
        chk("idle_data", mem_data_o, 0);
      end
      chk("ld_resp_v_o", ld_resp_v_o, resp_q.size() != 0);
      if (resp_q.size() != 0) begin
        re = resp_q.pop_front();
        chk("ld_resp_data_o", ld_resp_data_o, re);
      end else begin
        chk("resp_data_zero", ld_resp_data_o, 0);
      end
    end
  end

  initial begin
    // Reset with busy inputs: everything must stay quiet.
    reset_i = 1'b1;
    setin(1, 32'h20, 1, 32'h10, 32'hBEEF, 0, 1, 1, 32'h55);
    #2;
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_ld_ready", ld_ready_o, 0);
    chk("rst_yumi", sb_mem_yumi_o, 0);
    chk("rst_resp_v", ld_resp_v_o, 0);
    chk("rst_w", mem_w_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_resp_data", ld_resp_data_o, 0);
    tick();
    chk("rst_state", dut.state_q, 2'd0);
    chk("rst_starve", dut.starve_cnt_q, 0);
    reset_i = 1'b0;
    mon_en  = 1'b1;

    // Store alone
    setin(0, 0, 1, 32'h10, 32'hBEEF, 0, 1, 0, 0);
    exp_mem(1, 32'h10, 32'hBEEF, 0, 1);
    tick();
    chk("store_starve", dut.starve_cnt_q, 0);

    // Load, response two cycles later; retry in LD_WAIT must not be accepted
    setin(1, 32'h20, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h20, 0, 1, 0);
    tick();
    chk("ld_state_wait", dut.state_q, 2'd1);
    setin(1, 32'h20, 0, 0, 0, 0, 1, 0, 0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234);
    resp_q.push_back(32'h1234);
    tick();
    chk("ld_state_idle", dut.state_q, 2'd0);
    setin(1, 32'h24, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h24, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'h5678);
    resp_q.push_back(32'h5678);
    tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'h9999);
    tick();

    // Starvation: loads win four contested cycles, store wins the fifth
    for (int i = 0; i < 4; i++) begin
      setin(1, 32'h100 + 4 * i, 1, 32'h40, 32'hCAFE, 0, 1, 0, 0);
      exp_mem(0, 32'h100 + 4 * i, 0, 1, 0);
      tick();
      chk("starve_inc", dut.starve_cnt_q, i + 1);
      setin(1, 32'h100, 1, 32'h40, 32'hCAFE, 0, 0, 1, 32'hA000 + i);
      exp_mem(1, 32'h40, 32'hCAFE, 0, 0);
      resp_q.push_back(32'hA000 + i);
      tick();
      chk("starve_hold", dut.starve_cnt_q, i + 1);
    end
    setin(1, 32'h110, 1, 32'h40, 32'hCAFE, 0, 1, 0, 0);
    exp_mem(1, 32'h40, 32'hCAFE, 0, 1);
    tick();
    chk("starve_clear", dut.starve_cnt_q, 0);
    chk("starve_state", dut.state_q, 2'd0);
    setin(1, 32'h110, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h110, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'hB000);
    resp_q.push_back(32'hB000);
    tick();

    // Flush one cycle after accept, response three cycles after accept
    setin(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h200, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    chk("flush_squash", dut.state_q, 2'd2);
    setin(1, 32'h204, 1, 32'h50, 32'h1111, 0, 1, 0, 0);
    exp_mem(1, 32'h50, 32'h1111, 0, 1);
    tick();
    chk("flush_squash_hold", dut.state_q, 2'd2);
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD);
    tick();
    chk("flush_idle", dut.state_q, 2'd0);

    // Flush coincident with response, then flush blocking a load in IDLE
    setin(1, 32'h208, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h208, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 1, 1, 1, 32'hF00D);
    tick();
    chk("flush_rdv_idle", dut.state_q, 2'd0);
    setin(1, 32'h20C, 1, 32'h54, 32'h3333, 1, 1, 0, 0);
    exp_mem(1, 32'h54, 32'h3333, 0, 1);
    tick();

    // Backpressure on a lone store
    for (int i = 0; i < 3; i++) begin
      setin(0, 0, 1, 32'h60, 32'h2222, 0, 0, 0, 0);
      exp_mem(1, 32'h60, 32'h2222, 0, 0);
      tick();
      chk("bp_starve", dut.starve_cnt_q, 0);
    end
    setin(0, 0, 1, 32'h60, 32'h2222, 0, 1, 0, 0);
    exp_mem(1, 32'h60, 32'h2222, 0, 1);
    tick();

    // Asynchronous reset between edges while a response is on the bus
    setin(1, 32'h300, 0, 0, 0, 0, 1, 0, 0);
    exp_mem(0, 32'h300, 0, 1, 0);
    tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'h7777);
    #1;
    chk("pre_rst_resp_v", ld_resp_v_o, 1);
    #1;
    reset_i = 1'b1;
    #1;
    chk("arst_resp_v", ld_resp_v_o, 0);
    chk("arst_resp_data", ld_resp_data_o, 0);
    chk("arst_state", dut.state_q, 2'd0);
    tick();
    reset_i = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 1, 1, 32'h8888);
    tick();
    chk("post_rst_state", dut.state_q, 2'd0);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    mon_en = 1'b0;
    chk("mem_q_drained", mem_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
